// File: rtl/axis_bus_arbiter_pkg.sv
// Shared definitions for the AXIS bus arbiter and the mux it drives.
// Holds the mux select encoding, the default channel count, the arbiter
// FSM state encoding and a small width helper.
package axis_bus_arbiter_pkg;

    // Mux select codes: CHOOSE_BASE + idx routes source channel idx,
    // NON_FIFO_CHOOSE parks the mux with no source selected.
    localparam logic [7:0] CHOOSE_BASE     = 8'd128;
    localparam logic [7:0] NON_FIFO_CHOOSE = 8'd0;
    localparam int         NUM_CH_DEFAULT  = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } arb_state_t;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker.
//   req        : per-channel request flags
//   last_grant : channel granted most recently; search starts one above it
//   found      : at least one request is pending
//   idx        : first requesting channel at or after last_grant+1 (mod NUM_CH)
module axis_rr_pick
    import axis_bus_arbiter_pkg::*;
#(
    parameter  int NUM_CH = NUM_CH_DEFAULT,
    localparam int IDX_W  = idx_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  last_grant,
    output logic              found,
    output logic [IDX_W-1:0]  idx
);

    int cand;

    // Walk from the farthest offset to the nearest so the nearest
    // requester after last_grant is the one left standing.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise a latch is inferred.
        found = 1'b0;
        idx   = '0;
        cand  = 0;
        for (int off = NUM_CH; off >= 1; off--) begin
            cand = (int'(last_grant) + off) % NUM_CH;
            if (req[cand]) begin
                found = 1'b1;
                idx   = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/axis_bus_arbiter.sv
// Packet-level arbiter for an AXIS bus mux. Grants one source channel at a
// time in round-robin order, holds the grant until the packet's tlast beat
// is accepted (or the stream sits idle too long), and counts packets.
//   clk, rst_n   : clock, asynchronous active-low reset
//   req          : per-channel "whole packet available"
//   mon_tvalid   : tvalid seen at the mux output
//   mon_tlast    : tlast seen at the mux output
//   out_tready   : downstream ready
//   bus_sel      : mux select code (CHOOSE_BASE+idx while granted, else 0)
//   in_tready    : per-channel tready back to the sources
//   grant_active : a channel holds the bus
//   timeout_err  : one-cycle pulse when a grant is forcibly released
//   pkt_cnt      : completed packet count (wraps)
module axis_bus_arbiter
    import axis_bus_arbiter_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEFAULT,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] req,
    input  logic              mon_tvalid,
    input  logic              mon_tlast,
    input  logic              out_tready,
    output logic [7:0]        bus_sel,
    output logic [NUM_CH-1:0] in_tready,
    output logic              grant_active,
    output logic              timeout_err,
    output logic [15:0]       pkt_cnt
);

    localparam int IDX_W = idx_width(NUM_CH);
    localparam int CNT_W = idx_width(TIMEOUT_CYC);

    arb_state_t       state, state_n;
    logic [IDX_W-1:0] cur_idx, cur_idx_n;
    logic [IDX_W-1:0] last_grant, last_grant_n;
    logic [CNT_W-1:0] idle_cnt, idle_cnt_n;
    logic [7:0]       bus_sel_n;
    logic             grant_active_n;
    logic             timeout_err_n;
    logic [15:0]      pkt_cnt_n;

    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic             beat_ok;

    axis_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .found      (pick_found),
        .idx        (pick_idx)
    );

    assign beat_ok = (state == ST_XFER) && mon_tvalid && out_tready;

    // Ready is passed straight through to the granted source only, so the
    // source sees backpressure in the same cycle as the downstream.
    always_comb begin
        in_tready = '0;
        if (state == ST_XFER)
            in_tready[cur_idx] = out_tready;
    end

    always_comb begin
        state_n        = state;
        cur_idx_n      = cur_idx;
        last_grant_n   = last_grant;
        idle_cnt_n     = idle_cnt;
        bus_sel_n      = bus_sel;
        grant_active_n = grant_active;
        timeout_err_n  = 1'b0;
        pkt_cnt_n      = pkt_cnt;

        case (state)
            ST_IDLE: begin
                if (pick_found) begin
                    state_n        = ST_XFER;
                    cur_idx_n      = pick_idx;
                    idle_cnt_n     = '0;
                    bus_sel_n      = CHOOSE_BASE + 8'(pick_idx);
                    grant_active_n = 1'b1;
                end
            end
            ST_XFER: begin
                // tlast is checked first so it beats a timeout that lands
                // in the same cycle.
                if (beat_ok && mon_tlast) begin
                    state_n        = ST_IDLE;
                    last_grant_n   = cur_idx;
                    pkt_cnt_n      = pkt_cnt + 16'd1;
                    bus_sel_n      = NON_FIFO_CHOOSE;
                    grant_active_n = 1'b0;
                end else if (beat_ok) begin
                    idle_cnt_n = '0;
                end else if (idle_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                    state_n        = ST_IDLE;
                    last_grant_n   = cur_idx;
                    bus_sel_n      = NON_FIFO_CHOOSE;
                    grant_active_n = 1'b0;
                    timeout_err_n  = 1'b1;
                end else begin
                    idle_cnt_n = idle_cnt + 1'b1;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            cur_idx      <= '0;
            last_grant   <= IDX_W'(NUM_CH - 1);
            idle_cnt     <= '0;
            bus_sel      <= NON_FIFO_CHOOSE;
            grant_active <= 1'b0;
            timeout_err  <= 1'b0;
            pkt_cnt      <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples pre-edge values, independent of statement order.
            state        <= state_n;
            cur_idx      <= cur_idx_n;
            last_grant   <= last_grant_n;
            idle_cnt     <= idle_cnt_n;
            bus_sel      <= bus_sel_n;
            grant_active <= grant_active_n;
            timeout_err  <= timeout_err_n;
            pkt_cnt      <= pkt_cnt_n;
        end
    end

endmodule

// File: tb/tb_axis_bus_arbiter.sv
// Directed self-checking bench for axis_bus_arbiter (NUM_CH=10, TIMEOUT_CYC=16).
// Inputs change and outputs are sampled on the falling edge.
module tb_axis_bus_arbiter;

    localparam int NUM_CH = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM_CH-1:0] req;
    logic              mon_tvalid;
    logic              mon_tlast;
    logic              out_tready;
    logic [7:0]        bus_sel;
    logic [NUM_CH-1:0] in_tready;
    logic              grant_active;
    logic              timeout_err;
    logic [15:0]       pkt_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    axis_bus_arbiter #(.NUM_CH(NUM_CH), .TIMEOUT_CYC(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .mon_tvalid   (mon_tvalid),
        .mon_tlast    (mon_tlast),
        .out_tready   (out_tready),
        .bus_sel      (bus_sel),
        .in_tready    (in_tready),
        .grant_active (grant_active),
        .timeout_err  (timeout_err),
        .pkt_cnt      (pkt_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, act, act, exp, exp, $time);
        end
    endtask

    // One rising edge, then back to the falling edge for sampling/driving.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        req        = '0;
        mon_tvalid = 1'b0;
        mon_tlast  = 1'b0;
        out_tready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Streams n beats with tlast on the last one; checks ready routing per beat.
    task automatic send_pkt(input int n, input logic [NUM_CH-1:0] mask);
        mon_tvalid = 1'b1;
        out_tready = 1'b1;
        for (int i = 0; i < n; i++) begin
            mon_tlast = (i == n - 1);
            #1;
            check("pkt_in_tready", 32'(in_tready), 32'(mask));
            tick();
        end
        mon_tvalid = 1'b0;
        mon_tlast  = 1'b0;
    endtask

    logic [7:0] rr_exp [4];

    initial begin
        rr_exp[0] = 8'd128;
        rr_exp[1] = 8'd130;
        rr_exp[2] = 8'd137;
        rr_exp[3] = 8'd128;

        // Reset values and a single 3-beat packet on ch0.
        @(negedge clk);
        do_reset();
        check("rst_bus_sel", 32'(bus_sel), 32'd0);
        check("rst_in_tready", 32'(in_tready), 32'd0);
        check("rst_grant", 32'(grant_active), 32'd0);
        check("rst_timeout", 32'(timeout_err), 32'd0);
        check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        req = 10'b0000000001;
        tick();
        check("t1_bus_sel", 32'(bus_sel), 32'd128);
        check("t1_grant", 32'(grant_active), 32'd1);
        req = '0;
        send_pkt(3, 10'b0000000001);
        check("t1_idle_sel", 32'(bus_sel), 32'd0);
        check("t1_idle_grant", 32'(grant_active), 32'd0);
        check("t1_idle_rdy", 32'(in_tready), 32'd0);
        check("t1_pkt_cnt", 32'(pkt_cnt), 32'd1);

        // Round-robin over ch0, ch2, ch9 with req held.
        do_reset();
        req = 10'b1000000101;
        for (int g = 0; g < 4; g++) begin
            tick();
            check("rr_bus_sel", 32'(bus_sel), 32'(rr_exp[g]));
            check("rr_grant", 32'(grant_active), 32'd1);
            send_pkt(2, 10'(1) << (rr_exp[g] - 8'd128));
            check("rr_gap_sel", 32'(bus_sel), 32'd0);
        end
        req = '0;
        tick();
        check("rr_pkt_cnt", 32'(pkt_cnt), 32'd4);

        // Backpressure on ch3: no beats, no timeout, then completion.
        do_reset();
        req = 10'b0000001000;
        tick();
        check("bp_bus_sel", 32'(bus_sel), 32'd131);
        req        = '0;
        mon_tvalid = 1'b1;
        mon_tlast  = 1'b1;
        out_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_in_tready", 32'(in_tready), 32'd0);
            tick();
            check("bp_grant", 32'(grant_active), 32'd1);
        end
        check("bp_timeout", 32'(timeout_err), 32'd0);
        check("bp_pkt_hold", 32'(pkt_cnt), 32'd0);
        send_pkt(2, 10'b0000001000);
        check("bp_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("bp_idle_sel", 32'(bus_sel), 32'd0);

        // Timeout on ch5, then the next search starts at ch6.
        do_reset();
        req = 10'b0000100000;
        tick();
        check("to_bus_sel", 32'(bus_sel), 32'd133);
        req = '0;
        for (int i = 1; i < 16; i++) begin
            tick();
            check("to_no_pulse", 32'(timeout_err), 32'd0);
            check("to_grant", 32'(grant_active), 32'd1);
        end
        tick();
        check("to_pulse", 32'(timeout_err), 32'd1);
        check("to_bus_sel0", 32'(bus_sel), 32'd0);
        check("to_pkt_cnt", 32'(pkt_cnt), 32'd0);
        req = 10'b0001110000;
        tick();
        check("to_pulse_end", 32'(timeout_err), 32'd0);
        check("to_next_ch6", 32'(bus_sel), 32'd134);
        // Idle up to the threshold while req wiggles, then tlast on that cycle.
        for (int i = 0; i < 15; i++) begin
            req = 10'(i * 37 + 5);
            tick();
        end
        check("thr_sel_held", 32'(bus_sel), 32'd134);
        req = '0;
        send_pkt(1, 10'b0001000000);
        check("thr_no_pulse", 32'(timeout_err), 32'd0);
        check("thr_pkt_cnt", 32'(pkt_cnt), 32'd1);
        check("thr_idle", 32'(grant_active), 32'd0);

        // Asynchronous reset in the middle of a ch7 packet.
        do_reset();
        req = 10'b0010000000;
        tick();
        check("ar_bus_sel", 32'(bus_sel), 32'd135);
        mon_tvalid = 1'b1;
        out_tready = 1'b1;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_bus_sel0", 32'(bus_sel), 32'd0);
        check("ar_in_tready", 32'(in_tready), 32'd0);
        check("ar_grant", 32'(grant_active), 32'd0);
        check("ar_pkt_cnt", 32'(pkt_cnt), 32'd0);
        @(negedge clk);
        mon_tvalid = 1'b0;
        out_tready = 1'b0;
        rst_n      = 1'b1;
        req        = 10'b0010000001;
        tick();
        check("ar_first_ch0", 32'(bus_sel), 32'd128);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
